// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared types and default widths for apb_master_ctrl (optional macro APB_MASTER_TIMEOUT_EN)
package apb_master_pkg;

    localparam int APB_ADDR_WIDTH     = 32;
    localparam int APB_DATA_WIDTH     = 32;
    localparam int APB_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_mst_state_e;

    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [APB_DATA_WIDTH-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      error;
        logic                      timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// rtl/apb_timeout_counter.sv - ACCESS-phase wait counter, used only when APB_MASTER_TIMEOUT_EN is defined
module apb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] r_count;

    // Saturates at the final count so a stalled abort can never wrap back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - valid/ready command to APB setup/access master; APB_MASTER_TIMEOUT_EN adds an ACCESS timeout
module apb_master_ctrl
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_ready,
    input  logic                  m_error
);

    apb_mst_state_e        r_state;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_error;
    logic                  r_rsp_timeout;
    logic                  w_timeout_abort;

`ifdef APB_MASTER_TIMEOUT_EN
    logic w_tmo_expired;

    apb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .clk      (PCLK),
        .rst      (PRESET),
        .i_clear  (r_state == SETUP),
        .i_enable ((r_state == ACCESS) && !m_ready),
        .o_expired(w_tmo_expired)
    );

    // A slave completing on the final count still wins over the abort.
    assign w_timeout_abort = (r_state == ACCESS) && !m_ready && w_tmo_expired;
`else
    assign w_timeout_abort = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state       <= IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_pwrite <= cmd_write;
                        r_paddr  <= cmd_addr;
                        r_pwdata <= cmd_wdata;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (m_ready || w_timeout_abort) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= (r_pwrite || w_timeout_abort) ? '0 : m_rdata;
                        r_rsp_error   <= w_timeout_abort ? 1'b1 : m_error;
                        r_rsp_timeout <= w_timeout_abort;
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = (r_state == IDLE);
    assign PSELx       = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_error   = r_rsp_error;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- APB master stage directly upstream of apb_top. It converts a simple valid/ready command interface into APB setup/access phases on PSELx/PENABLE/PWRITE/PADDR/PWDATA.
- It consumes the slave's completion (m_ready, m_rdata, m_error) and returns one response per command on a valid/ready response interface.
- One outstanding transfer at a time; no pipelining across APB transfers.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr/PADDR
- DATA_WIDTH, 32, width of cmd_wdata/PWDATA/m_rdata/rsp_rdata
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before abort (used only with macro)

Ports:
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_error  out  1  slave error or timeout
- rsp_timeout  out  1  transfer aborted by timeout; tied 0 without macro
- PSELx, PENABLE, PWRITE  out  1 each  APB controls to apb_top
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- m_rdata  in  DATA_WIDTH  slave read data
- m_ready  in  1  slave ready (PREADY)
- m_error  in  1  slave error (PSLVERR), valid only with m_ready

Behaviour:
- Clock and reset: single clock PCLK; reset is asynchronous and active-high on PRESET.
- Reset: all outputs registered and 0 at reset, except cmd_ready, which is combinational (state==IDLE) and therefore 1 during reset. State = IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On handshake, register cmd_write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
- SETUP (exactly 1 cycle): PSELx=1, PENABLE=0; next state ACCESS.
- ACCESS:
  - PSELx=1, PENABLE=1.
  - Stay while m_ready=0.
  - On m_ready=1: capture rsp_rdata = PWRITE ? 0 : m_rdata, rsp_error = m_error. Next cycle PSELx=0, PENABLE=0, rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid and rsp_* held stable until rsp_ready.
  - On handshake: rsp_valid=0, go to IDLE.
  - rsp_ready asserted on the first RESP cycle completes in that cycle.
- Bus stability: PADDR/PWDATA/PWRITE change only on command acceptance and hold their last value in IDLE/RESP. PENABLE is never 1 while PSELx is 0.
- Latency:
  - Accept to first PSELx = 1 cycle.
  - Zero-wait slave: accept at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3.
  - Minimum 4-cycle command-to-command throughput.
- cmd_ready is 0 outside IDLE; a cmd_valid arriving then waits and is not dropped.
- m_ready and m_error are ignored outside ACCESS.
- Reset mid-transfer: PSELx/PENABLE/rsp_valid drop immediately (asynchronously); the transfer is lost and no response is issued.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- With the macro:
  - A counter clears on entering ACCESS and increments each ACCESS cycle with m_ready=0.
  - When the count reaches TIMEOUT_CYCLES-1 with m_ready still 0, abort: next cycle PSELx=PENABLE=0, rsp_valid=1, rsp_error=1, rsp_timeout=1, rsp_rdata=0.
  - m_ready=1 on the final-count cycle wins: normal completion.
- Without the macro: ACCESS waits indefinitely and rsp_timeout is constant 0.

Decomposition:
- Package apb_master_pkg:
  - enum apb_mst_state_e {IDLE, SETUP, ACCESS, RESP}
  - struct apb_cmd_t {write, addr, wdata}
  - struct apb_rsp_t {rdata, error, timeout}
  - default width localparams
- Sub-module apb_timeout_counter (enable/clear in, expired out, width $clog2(TIMEOUT_CYCLES)), instantiated only under APB_MASTER_TIMEOUT_EN.

Test Plan:
- Write addr=0x04, wdata=0xDEADBEEF, m_ready tied 1 -> SETUP then ACCESS seen with PADDR=0x04, PWDATA=0xDEADBEEF, PWRITE=1; rsp_valid at cycle 3 with rsp_error=0, rsp_rdata=0.
- Read addr=0x10, slave inserts 3 wait states, then m_rdata=0x12345678 -> PENABLE high 4 cycles; rsp_rdata=0x12345678.
- Read with m_error=1 on the ready cycle -> rsp_error=1, rsp_timeout=0; with m_error=1 but m_ready=0, the error is ignored.
- Response backpressure (rsp_ready=0 for 5 cycles) plus a second cmd_valid -> cmd_ready stays 0; rsp_* stable; second command accepted in the cycle after the response handshake.
- PRESET pulsed during ACCESS -> PSELx/PENABLE 0 without waiting for a clock edge; no rsp_valid; next command runs normally.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, m_ready held 0 -> 16 ACCESS cycles, then rsp_error=1, rsp_timeout=1, rsp_rdata=0, PSELx=0.
